// File: rtl/window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : window_fetch
// Purpose  : Pipelined Wishbone gather of a KxK window into a flat element bank.
// Revision : 1.0
// ============================================================================
module window_fetch #(
    parameter int DW      = 16,
    parameter int K_MAX   = 3,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic                      start,
    input  logic [AW-1:0]             base_addr,
    input  logic [15:0]               row_stride,
    input  logic [3:0]                win_k,
    output logic [K_MAX*K_MAX*DW-1:0] window,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    input  logic [31:0]               data_o,
    input  logic                      stall_o,
    input  logic                      sdram_ack,
    output logic                      stb_i,
    output logic                      cyc_i,
    output logic                      we_i,
    output logic [3:0]                sel_i,
    output logic [AW-1:0]             addr_i,
    output logic [31:0]               data_i
);

    localparam int              c_NE       = K_MAX * K_MAX;
    localparam int              c_CW       = $clog2(c_NE + 1);
    localparam int              c_TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      c_KMAX     = 4'(K_MAX);
    localparam logic [3:0]      c_SEL      = 4'((1 << (DW / 8)) - 1);
    localparam logic [AW-1:0]   c_ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t          r_state;
    logic [15:0]     r_stride;
    logic [3:0]      r_k;
    logic [c_CW-1:0] r_n;
    logic [c_CW-1:0] r_iss;
    logic [c_CW-1:0] r_ack;
    logic [3:0]      r_col;
    logic [AW-1:0]   r_rowbase;
    logic [AW-1:0]   r_addr;
    logic            r_stb;
    logic            r_cyc;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [c_TW-1:0] r_tmo;
    logic [DW-1:0]   r_elem [c_NE];

    logic            w_accept;
    logic            w_take;
    logic            w_k_ok;
    logic            w_last_col;
    logic            w_waiting;
    logic [c_CW-1:0] w_iss_nxt;
    logic [c_CW-1:0] w_ack_nxt;
    logic [c_CW-1:0] w_n_start;
    logic [AW-1:0]   w_row_next;

    assign w_accept   = r_stb & ~stall_o;
    assign w_waiting  = (r_ack < r_iss);
    assign w_take     = sdram_ack & w_waiting;
    assign w_k_ok     = (win_k != 4'd0) && (win_k <= c_KMAX);
    assign w_last_col = (r_col == (r_k - 4'd1));
    assign w_iss_nxt  = r_iss + c_CNT_ONE;
    assign w_ack_nxt  = r_ack + c_CNT_ONE;
    // Only evaluated for validated win_k, so the product always fits the counter width.
    assign w_n_start  = c_CW'(win_k) * c_CW'(win_k);
    // Row base accumulates the stride so no address multiplier is needed.
    assign w_row_next = r_rowbase + {{(AW-16){1'b0}}, r_stride};

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_stride  <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_iss     <= '0;
            r_ack     <= '0;
            r_col     <= '0;
            r_rowbase <= '0;
            r_addr    <= '0;
            r_stb     <= 1'b0;
            r_cyc     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo     <= '0;
            for (int i = 0; i < c_NE; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!w_k_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_stride  <= row_stride;
                            r_k       <= win_k;
                            r_n       <= w_n_start;
                            r_iss     <= '0;
                            r_ack     <= '0;
                            r_col     <= '0;
                            r_tmo     <= '0;
                            r_rowbase <= base_addr;
                            r_addr    <= base_addr;
                            r_stb     <= 1'b1;
                            r_cyc     <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= S_FETCH;
                            for (int i = 0; i < c_NE; i++) begin
                                r_elem[i] <= '0;
                            end
                        end
                    end
                end

                S_FETCH: begin
                    if (w_accept) begin
                        r_iss <= w_iss_nxt;
                        if (w_iss_nxt == r_n) begin
                            r_stb <= 1'b0;
                        end else if (w_last_col) begin
                            r_col     <= '0;
                            r_rowbase <= w_row_next;
                            r_addr    <= w_row_next;
                        end else begin
                            r_col  <= r_col + 4'd1;
                            r_addr <= r_addr + c_ADDR_ONE;
                        end
                    end

                    if (w_take) begin
                        r_elem[r_ack] <= data_o[DW-1:0];
                        r_ack         <= w_ack_nxt;
                    end

                    if (sdram_ack) begin
                        r_tmo <= '0;
                    end else if (w_waiting) begin
                        r_tmo <= r_tmo + c_TMO_ONE;
                    end

                    if (w_take && (w_ack_nxt == r_n)) begin
                        r_stb   <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (!sdram_ack && w_waiting && (r_tmo == c_TMO_LAST)) begin
                        r_stb   <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Element 0 lands in the most significant slice of the flat bus.
    for (genvar gi = 0; gi < c_NE; gi++) begin : g_pack
        assign window[(c_NE-1-gi)*DW +: DW] = r_elem[gi];
    end

    if (DW < 32) begin : g_data_tie
        logic w_unused_data;
        assign w_unused_data = &{1'b0, data_o[31:DW]};
    end

    assign stb_i  = r_stb;
    assign cyc_i  = r_cyc;
    assign addr_i = r_addr;
    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign we_i   = 1'b0;
    assign sel_i  = c_SEL;
    assign data_i = 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_window_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_fetch
// Purpose  : Self-checking bench for window_fetch with a queued Wishbone slave.
// Revision : 1.0
// ============================================================================
module tb_window_fetch;

    localparam int DW    = 16;
    localparam int K_MAX = 3;
    localparam int AW    = 32;
    localparam int TMO   = 255;
    localparam int NE    = K_MAX * K_MAX;
    localparam int WW    = NE * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [15:0]   row_stride = '0;
    logic [3:0]    win_k = '0;
    logic [WW-1:0] window;
    logic          busy, done, err;
    logic [31:0]   data_o = '0;
    logic          stall_o = 1'b0;
    logic          sdram_ack = 1'b0;
    logic          stb_i, cyc_i, we_i;
    logic [3:0]    sel_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   data_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration and bookkeeping
    bit            slv_en = 1'b0;
    bit            slv_plus = 1'b0;
    int            slv_lat = 1;
    int            slv_mode = 0;
    int            slv_limit = 1000;
    logic [31:0]   slv_salt = 32'h1234_5678;
    int            slv_ncyc = 0;
    int            acks_given = 0;
    int            last_ack_ncyc = 0;
    bit            stall_tgl = 1'b0;
    logic [AW-1:0] req_q[$];
    logic [AW-1:0] pend_a[$];
    int            pend_d[$];

    window_fetch #(.DW(DW), .K_MAX(K_MAX), .AW(AW), .TIMEOUT(TMO)) dut (
        .CLK(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_stride(row_stride), .win_k(win_k), .window(window),
        .busy(busy), .done(done), .err(err), .data_o(data_o),
        .stall_o(stall_o), .sdram_ack(sdram_ack), .stb_i(stb_i),
        .cyc_i(cyc_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
        .data_i(data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
        if (slv_plus) return a + 32'h100;
        return (a * 32'h9E37_79B1) ^ slv_salt;
    endfunction

    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input logic [15:0] stride,
                                                 input int r, input int c);
        return base + AW'(r) * {16'd0, stride} + AW'(c);
    endfunction

    // Element i = r*k + c holds the word at base + r*stride + c; unfilled slots stay zero.
    function automatic logic [WW-1:0] model_window(input logic [AW-1:0] base, input logic [15:0] stride,
                                                   input int k, input int nvalid);
        logic [WW-1:0] w;
        logic [31:0]   d;
        int            i;
        w = '0;
        for (int r = 0; r < k; r++) begin
            for (int c = 0; c < k; c++) begin
                i = r * k + c;
                if (i < nvalid) begin
                    d = mem_data(model_addr(base, stride, r, c));
                    w[(NE-1-i)*DW +: DW] = d[DW-1:0];
                end
            end
        end
        return w;
    endfunction

    // Slave acts on the falling edge so its outputs are settled for the next rising edge.
    always @(negedge clk) begin
        if (!slv_en) begin
            pend_a.delete();
            pend_d.delete();
            req_q.delete();
            acks_given = 0;
            slv_ncyc   = 0;
            stall_tgl  = 1'b0;
            sdram_ack  = 1'b0;
            stall_o    = 1'b0;
            data_o     = '0;
        end else begin
            slv_ncyc++;
            sdram_ack = 1'b0;
            data_o    = $urandom;
            if (pend_a.size() > 0 && pend_d[0] <= slv_ncyc) begin
                logic [AW-1:0] pa;
                pa = pend_a.pop_front();
                void'(pend_d.pop_front());
                if (acks_given < slv_limit) begin
                    sdram_ack     = 1'b1;
                    data_o        = mem_data(pa);
                    acks_given++;
                    last_ack_ncyc = slv_ncyc;
                end
            end
            case (slv_mode)
                1: begin stall_tgl = ~stall_tgl; stall_o = stall_tgl; end
                2: stall_o = ($urandom_range(0, 2) == 0);
                default: stall_o = 1'b0;
            endcase
            if (stb_i && cyc_i && !stall_o && !rst) begin
                req_q.push_back(addr_i);
                pend_a.push_back(addr_i);
                pend_d.push_back(slv_ncyc + slv_lat);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", name, obs, exp);
        end
    endtask

    task automatic slave_cfg(input int lat, input int mode, input int limit, input bit plus);
        slv_en = 1'b0;
        step();
        slv_lat   = lat;
        slv_mode  = mode;
        slv_limit = limit;
        slv_plus  = plus;
        slv_salt  = $urandom;
        step();
        slv_en = 1'b1;
    endtask

    // Returns with cnt = falling edges after the start-sampling edge when done/err was seen.
    task automatic do_fetch(input logic [AW-1:0] base, input logic [15:0] stride, input int k,
                            input int dup_at, output int cnt, output bit got_done, output bit got_err);
        step();
        base_addr  = base;
        row_stride = stride;
        win_k      = 4'(k);
        start      = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
        check("first_busy", WW'(busy), WW'(1));
        check("first_addr", WW'(addr_i), WW'(base));
        check("first_stb_cyc", WW'({stb_i, cyc_i}), WW'(2'b11));
        while (!done && !err && cnt < 2000) begin
            if (dup_at > 0 && cnt == dup_at) begin
                base_addr = base ^ 32'h0005_A5A0;
                start     = 1'b1;
            end
            step();
            start = 1'b0;
            cnt++;
        end
        got_done = done;
        got_err  = err;
    endtask

    task automatic fetch_check(input string tag, input logic [AW-1:0] base, input logic [15:0] stride,
                               input int k, input int dup_at);
        int cnt;
        bit gd, ge;
        do_fetch(base, stride, k, dup_at, cnt, gd, ge);
        check({tag, "_done"}, WW'({gd, ge}), WW'(2'b10));
        check({tag, "_nreq"}, WW'(req_q.size()), WW'(k * k));
        for (int i = 0; i < k * k; i++) begin
            check({tag, "_addr"}, WW'(req_q[i]), WW'(model_addr(base, stride, i / k, i % k)));
        end
        check({tag, "_window"}, window, model_window(base, stride, k, k * k));
        step();
        check({tag, "_done_pulse"}, WW'(done), WW'(0));
    endtask

    initial begin
        int            cnt, guard;
        bit            gd, ge;
        logic [AW-1:0] b;
        logic [15:0]   s;
        logic [WW-1:0] exp_prev;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check("rst_window", window, '0);
        check("rst_flags", WW'({busy, done, err, stb_i, cyc_i}), WW'(0));
        check("rst_addr", WW'(addr_i), WW'(0));
        check("const_bus", WW'({we_i, sel_i, data_i}), WW'({1'b0, 4'b0011, 32'd0}));

        // Zero-wait 3x3 kernel: done on the 10th edge after the start edge (11 cycles total).
        slave_cfg(1, 0, 1000, 1'b1);
        do_fetch(32'h10, 16'd3, 3, 0, cnt, gd, ge);
        check("zw_latency", WW'(cnt), WW'(10));
        check("zw_done", WW'({gd, ge}), WW'(2'b10));
        check("zw_idle_at_done", WW'({busy, cyc_i, stb_i}), WW'(0));
        for (int i = 0; i < 9; i++) check("zw_addr", WW'(req_q[i]), WW'(32'h10 + i));
        check("zw_window", window, 144'h0110_0111_0112_0113_0114_0115_0116_0117_0118);
        step();
        check("zw_done_pulse", WW'(done), WW'(0));

        // Strided 2x2 patch, alternating stall, ack latency 3.
        slave_cfg(3, 1, 1000, 1'b0);
        fetch_check("stall2x2", 32'h40, 16'd28, 2, 0);

        // Only four acks: err after TIMEOUT idle cycles, partial data retained.
        slave_cfg(1, 0, 4, 1'b0);
        b = $urandom;
        s = 16'($urandom);
        do_fetch(b, s, 3, 0, cnt, gd, ge);
        check("tmo_flags", WW'({gd, ge}), WW'(2'b01));
        check("tmo_delay", WW'(slv_ncyc - last_ack_ncyc), WW'(TMO + 1));
        check("tmo_bus", WW'({cyc_i, stb_i, busy}), WW'(0));
        check("tmo_nreq", WW'(req_q.size()), WW'(9));
        exp_prev = model_window(b, s, 3, 4);
        check("tmo_window", window, exp_prev);
        step();
        check("tmo_err_pulse", WW'(err), WW'(0));

        // Invalid window sizes.
        slave_cfg(1, 0, 1000, 1'b0);
        for (int t = 0; t < 2; t++) begin
            step();
            win_k     = (t == 0) ? 4'd0 : 4'd4;
            base_addr = 32'h200;
            start     = 1'b1;
            step();
            start = 1'b0;
            check("inv_err", WW'(err), WW'(1));
            check("inv_bus", WW'({stb_i, cyc_i, busy}), WW'(0));
            step();
            check("inv_err_pulse", WW'(err), WW'(0));
            check("inv_bus2", WW'({stb_i, cyc_i, busy}), WW'(0));
            check("inv_window", window, exp_prev);
        end
        check("inv_nreq", WW'(req_q.size()), WW'(0));

        // Reset in the middle of a fetch; remaining acks arrive late.
        slave_cfg(3, 0, 1000, 1'b0);
        step();
        base_addr  = 32'h300;
        row_stride = 16'd10;
        win_k      = 4'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (acks_given < 5 && guard < 100) begin
            step();
            guard++;
        end
        check("rstm_reach5", WW'(acks_given >= 5), WW'(1));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstm_bus", WW'({cyc_i, stb_i, busy}), WW'(0));
        check("rstm_window", window, '0);
        guard = 0;
        while (pend_a.size() > 0 && guard < 20) begin
            step();
            guard++;
        end
        step();
        check("rstm_late_ack_seen", WW'(acks_given > 5), WW'(1));
        check("rstm_late_window", window, '0);
        check("rstm_late_flags", WW'({done, err, busy}), WW'(0));
        slave_cfg(1, 0, 1000, 1'b0);
        fetch_check("rstm_after", 32'h300, 16'd10, 3, 0);

        // A second start while busy must be ignored.
        slave_cfg(2, 2, 1000, 1'b0);
        fetch_check("dup_start", 32'h1000, 16'd64, 3, 3);

        // Random fetches; the first one wraps the address space.
        for (int it = 0; it < 12; it++) begin
            slave_cfg($urandom_range(1, 4), $urandom_range(0, 2), 1000, 1'b0);
            if (it == 0) begin
                b = 32'hFFFF_FFFE;
                s = 16'hFFFF;
            end else begin
                b = $urandom;
                s = 16'($urandom);
            end
            fetch_check("rand", b, s, $urandom_range(1, 3), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_fetch.md
Name: window_fetch

Overview:
- Parametrised Wishbone read engine that gathers a square KxK window of DW-bit elements from SDRAM into a flat register bank.
- Used for both kernels (row_stride = K) and feature-map patches (row_stride = map width).
- Replaces per-layer hand-coded gather states with one reusable block.
- Feeds the conv_3_3 / maxpool datapaths and sits between the network controller FSM and the SDRAM Wishbone port.
- Supports pipelined (stall-aware) reads, multiple outstanding requests, runtime window size, and an ack timeout.

Parameters:
DW, 16, element width in bits; must be a multiple of 8 and ≤ 32.
K_MAX, 3, maximum window edge; bank holds K_MAX*K_MAX elements.
AW, 32, Wishbone address width.
TIMEOUT, 255, cycles without ack (while requests are outstanding) before abort.

Ports:
CLK  in  1  clock, all logic on rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  one-cycle request to begin a fetch; sampled only in IDLE.
base_addr  in  AW  address of element (0,0); sampled at start.
row_stride  in  16  address increment between window rows; sampled at start.
win_k  in  4  window edge K for this fetch; sampled at start.
window  out  K_MAX*K_MAX*DW  element i at bits [(K_MAX*K_MAX-1-i)*DW +: DW] (element 0 in the MSBs), where i = r*K + c.
busy  out  1  high from the cycle after an accepted start until the cycle of done/err.
done  out  1  one-cycle pulse when all K*K elements are stored.
err  out  1  one-cycle pulse on invalid win_k or timeout.
data_o  in  32  Wishbone read data; element taken from data_o[DW-1:0].
stall_o  in  1  Wishbone stall; a request is accepted when stb_i=1 and stall_o=0.
sdram_ack  in  1  Wishbone ack, one per accepted request, in order.
stb_i  out  1  request strobe.
cyc_i  out  1  bus cycle.
we_i  out  1  constant 0.
sel_i  out  4  constant low DW/8 bits set (0011 for DW=16).
addr_i  out  AW  request address.
data_i  out  32  constant 0.

Behaviour:
- All outputs are registered. Reset values: stb_i=0, cyc_i=0, addr_i=0, busy=0, done=0, err=0, window all zeros. Internal counters clear; state goes to IDLE.
- States: IDLE, FETCH.
- IDLE, on start:
  - If win_k==0 or win_k>K_MAX: pulse err next cycle and stay in IDLE. No bus activity occurs and window is unchanged.
  - Otherwise: latch parameters, set N=K*K, zero the whole window bank, and enter FETCH. On the next cycle busy=1, cyc_i=1, stb_i=1, addr_i=base_addr.
- FETCH, issue side:
  - Issue counter iss (0..N) with row/col counters r,c. Address = base_addr + r*row_stride + c, computed incrementally with a row-base accumulator (no multiplier), wrapping modulo 2^AW.
  - On each accepted request (stb_i & ~stall_o): iss++ and addr_i advances to the next element.
  - stb_i drops in the cycle after the N-th request is accepted.
  - While stall_o=1, stb_i and addr_i hold.
- FETCH, ack side:
  - Ack counter ack_cnt (0..N). On sdram_ack with ack_cnt<iss, store data_o[DW-1:0] into element ack_cnt, then ack_cnt++.
  - Acks arriving when ack_cnt==iss, or in IDLE, are ignored.
- Completion: at the edge that stores element N-1, on the next cycle cyc_i=0, stb_i=0, busy=0, done=1 for one cycle, and the state returns to IDLE. window is stable from the done cycle until the next accepted start.
- Latency, zero-wait slave (stall_o=0, ack one cycle after request): start sampled at edge 0; requests at edges 1..N; acks at edges 2..N+1; done high in the cycle after edge N+1. Total N+2 cycles.
- Timeout:
  - Counter increments every FETCH cycle with ack_cnt<iss and no sdram_ack; it clears on any ack.
  - On reaching TIMEOUT: cyc_i=0, stb_i=0, err pulses, busy=0, return to IDLE.
  - window retains partial data; done is not asserted.
- start during FETCH is ignored. A start in the same cycle as done/err is also ignored, because the state is still FETCH.
- rst mid-FETCH: cyc_i/stb_i are 0 the following cycle and window is cleared. Late acks are ignored.
- Simultaneous accept and ack in one cycle: both counters update. The ack stores to the old ack_cnt.

Test Plan:
- Zero-wait 3x3 kernel: base=0x10, stride=3, win_k=3, slave returns addr+0x100 -> addr_i sequence 0x10..0x18; window = 0x0110..0x0118 with 0x0110 in the MSBs; done exactly 11 cycles after start; cyc_i low the same cycle as done.
- Strided 2x2 patch with stalls: base=0x40, stride=28, win_k=2, stall_o high every other cycle, ack latency 3 -> addresses 0x40,0x41,0x5C,0x5D, each held across stalls; window[MSB 4 elements] = those data; remaining 5 elements = 0.
- Timeout: win_k=3, slave acks only 4 requests -> err pulses TIMEOUT cycles after the 4th ack; elements 0..3 are valid; no done; cyc_i=0.
- Invalid size: win_k=0, then win_k=4 (K_MAX=3) -> err pulse each time; stb_i/cyc_i never assert; busy stays 0.
- Reset mid-fetch: assert rst after 5 acks of a 3x3 fetch -> next cycle cyc_i=0, window=0; a late ack does not change window; a following normal fetch completes correctly.
- start while busy: pulse start with different base_addr during FETCH -> ignored; addresses and result match the original request.
